// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction-memory address and loads the IF/ID register.
// Latency: imem_addr is combinational from PC/state; IF/ID fields update one clk after the fetch.
// Backpressure: pc_write_en=0 freezes PC/state; if_id_write_en/inject_bubble gate IF/ID loading.
// Ports: clk, rst (async, active-low); imem_addr/imem_rdata to instruction memory;
//   pc_write_en, if_id_write_en, inject_bubble from control; branch_*/ret_* redirect requests;
//   intr external interrupt level; if_id_* pipeline register; intr_ret_pc/intr_ack to the ISR push.
module fetch_stage #(
    parameter int              ADDR_W         = 8,
    parameter int              DATA_W         = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00,
    parameter logic [ADDR_W-1:0] INTR_VEC_ADDR  = 8'h01,
    parameter logic [3:0]      IMM_OPCODE     = 4'hC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              pc_write_en,
    input  logic              if_id_write_en,
    input  logic              inject_bubble,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              ret_taken,
    input  logic [ADDR_W-1:0] ret_pc,
    input  logic              intr,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic [DATA_W-1:0] if_id_imm,
    output logic              if_id_imm_valid,
    output logic [ADDR_W-1:0] intr_ret_pc,
    output logic              intr_ack
);
    typedef enum logic [1:0] {S_RSTVEC, S_RUN, S_IMM, S_INTVEC} state_t;

    localparam logic [DATA_W-1:0] NOP = '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] pp1_q, pp1_d;
    logic [ADDR_W-1:0] irp_q, irp_d;
    logic              iv_q, iv_d;
    logic              pend_q, pend_d;
    logic              intr_d1_q;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] rdata_pc;
    logic              redirect;
    logic              intr_rise;
    logic              is_imm_op;

    assign pc_plus1    = pc_q + ADDR_W'(1);
    assign redirect    = ret_taken | branch_taken;
    assign redirect_pc = ret_taken ? ret_pc : branch_target;   // RET/RTI beats branch
    assign rdata_pc    = ADDR_W'(imem_rdata);
    assign intr_rise   = intr & ~intr_d1_q;
    assign is_imm_op   = (imem_rdata[DATA_W-1 -: 4] == IMM_OPCODE);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        pp1_d     = pp1_q;
        irp_d     = irp_q;
        iv_d      = iv_q;
        pend_d    = pend_q | intr_rise;
        imem_addr = pc_q;
        intr_ack  = 1'b0;

        case (state_q)
            S_RSTVEC: begin
                imem_addr = RESET_VEC_ADDR;
                pc_d      = rdata_pc;
                instr_d   = NOP;
                iv_d      = 1'b0;
                state_d   = S_RUN;
            end
            S_INTVEC: begin
                imem_addr = INTR_VEC_ADDR;
                intr_ack  = 1'b1;
                pc_d      = rdata_pc;
                instr_d   = NOP;
                iv_d      = 1'b0;
                // A fresh edge landing in this very cycle must not be lost.
                pend_d    = intr_rise;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    instr_d = NOP;
                    iv_d    = 1'b0;
                end else if (pc_write_en && pend_q) begin
                    // Take the interrupt instead of this fetch; the byte at PC is refetched on return.
                    irp_d   = pc_q;
                    state_d = S_INTVEC;
                    if (if_id_write_en) begin
                        instr_d = NOP;
                        iv_d    = 1'b0;
                    end
                end else begin
                    if (pc_write_en) begin
                        pc_d    = pc_plus1;
                        state_d = is_imm_op ? S_IMM : S_RUN;
                    end
                    if (if_id_write_en) begin
                        iv_d = 1'b0;
                        if (inject_bubble) begin
                            instr_d = NOP;
                        end else begin
                            instr_d = imem_rdata;
                            pp1_d   = pc_plus1;
                        end
                    end
                end
            end
            S_IMM: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    instr_d = NOP;
                    iv_d    = 1'b0;
                    state_d = S_RUN;
                end else begin
                    if (pc_write_en) begin
                        pc_d    = pc_plus1;
                        state_d = S_RUN;
                    end
                    // The opcode stays in if_id_instr; control already issued its bubble.
                    if (if_id_write_en) begin
                        imm_d = imem_rdata;
                        iv_d  = 1'b1;
                        pp1_d = pc_plus1;
                    end
                end
            end
            default: state_d = S_RSTVEC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RSTVEC;
            pc_q      <= '0;
            instr_q   <= NOP;
            imm_q     <= '0;
            pp1_q     <= '0;
            irp_q     <= '0;
            iv_q      <= 1'b0;
            pend_q    <= 1'b0;
            intr_d1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pp1_q     <= pp1_d;
            irp_q     <= irp_d;
            iv_q      <= iv_d;
            pend_q    <= pend_d;
            intr_d1_q <= intr;
        end
    end

    assign if_id_instr     = instr_q;
    assign if_id_pc_plus1  = pp1_q;
    assign if_id_imm       = imm_q;
    assign if_id_imm_valid = iv_q;
    assign intr_ret_pc     = irp_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 8-bit pipelined core. Sits directly upstream of the decode/control unit.
- Owns the PC, drives the instruction-memory address and loads the IF/ID pipeline register (instr, pc_plus1, imm).
- Handles reset-vector load, two-byte (opcode 12: LDM/LDD/STD) immediate capture, interrupt-vector entry, and redirects from branch/RET/RTI.
- Obeys the stall/bubble controls produced by the control unit.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- DATA_W, 8, instruction byte width.
- RESET_VEC_ADDR, 8'h00, memory word holding the reset entry PC.
- INTR_VEC_ADDR, 8'h01, memory word holding the ISR entry PC.
- IMM_OPCODE, 4'hC, opcode whose instruction carries a second (immediate) byte.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- imem_addr  out  ADDR_W  instruction-memory address (combinational).
- imem_rdata  in  DATA_W  instruction-memory data, combinational read of imem_addr.
- pc_write_en  in  1  0 = hold PC and state (stall).
- if_id_write_en  in  1  0 = hold IF/ID register.
- inject_bubble  in  1  1 = load NOP (8'h00) into if_id_instr.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  ADDR_W  redirect target.
- ret_taken  in  1  RET/RTI redirect request from memory stage.
- ret_pc  in  ADDR_W  popped return PC.
- intr  in  1  external interrupt, level; rising edge latched.
- if_id_instr  out  DATA_W  registered instruction byte.
- if_id_pc_plus1  out  ADDR_W  registered PC+1 of that instruction (CALL return address).
- if_id_imm  out  DATA_W  registered immediate byte.
- if_id_imm_valid  out  1  if_id_imm belongs to the current if_id_instr.
- intr_ret_pc  out  ADDR_W  PC to be pushed by the interrupt sequence.
- intr_ack  out  1  one-cycle pulse when ISR vector is taken.

Behaviour:
- Reset (rst=0, async):
  - PC=0, state=S_RSTVEC, intr_pending=0.
  - All if_id_* outputs 0 (instr = NOP), intr_ret_pc=0, intr_ack=0.
- States: S_RSTVEC, S_RUN, S_IMM, S_INTVEC.
- imem_addr:
  - RESET_VEC_ADDR in S_RSTVEC.
  - INTR_VEC_ADDR in S_INTVEC.
  - Otherwise PC.
- S_RSTVEC: PC<=imem_rdata; IF/ID<=NOP; ->S_RUN. Ignores the stall, redirect and bubble inputs.
- Priority within S_RUN/S_IMM: redirect > stall > interrupt > normal fetch.
- Redirect:
  - ret_taken beats branch_taken.
  - PC<=ret_pc or branch_target; IF/ID instr<=NOP; imm_valid<=0.
  - ->S_RUN, also aborting S_IMM.
- Stall (pc_write_en=0): PC and state hold. IF/ID follows if_id_write_en and inject_bubble independently.
- IF/ID update:
  - if_id_write_en=0 holds; otherwise inject_bubble=1 loads NOP; otherwise loads the fetched data.
  - A redirect always loads NOP regardless of these inputs.
- S_RUN normal fetch:
  - if_id_instr<=imem_rdata; if_id_pc_plus1<=PC+1; imm_valid<=0; PC<=PC+1.
  - If imem_rdata[7:4]==IMM_OPCODE, ->S_IMM; else stay.
- S_IMM:
  - if_id_imm<=imem_rdata; imm_valid<=1; if_id_pc_plus1<=PC+1; PC<=PC+1.
  - if_id_instr held internally even if inject_bubble=1 (bubble already issued by control); ->S_RUN.
- Interrupt latch: rising edge of intr (registered 1-cycle delay) sets intr_pending. Pending persists until taken.
- Interrupt entry:
  - Taken only in S_RUN with pending=1, no redirect, no stall, and no two-byte instruction currently being fetched.
  - Instead of fetching: intr_ret_pc<=PC; IF/ID<=NOP; ->S_INTVEC.
- S_INTVEC: PC<=imem_rdata; intr_ack=1 for this cycle; pending<=0; IF/ID<=NOP; ->S_RUN. A redirect arriving in S_INTVEC is ignored.
- Arithmetic: PC+1 is modulo 2^ADDR_W; 8'hFF wraps to 8'h00.
- Simultaneous intr edge and redirect: redirect executes; pending stays set and is taken at the next eligible cycle.
- Reset mid-operation (any state): immediate return to reset values. The vector is re-fetched on the first clock after release.

Test Plan:
- Reset vector: M[0]=8'h20, M[0x20]=8'h12, release rst -> cycle1 PC=8'h20, if_id_instr=00; cycle2 if_id_instr=8'h12, if_id_pc_plus1=8'h21.
- Two-byte: M[0x20]=8'hC4, M[0x21]=8'h5A -> if_id_instr=C4 then if_id_imm=5A, imm_valid=1, PC=8'h22; next byte fetched from 0x22.
- Stall: pc_write_en=0, if_id_write_en=0 for 3 cycles -> PC and all if_id_* unchanged; resume continues at the same address.
- Redirect during S_IMM: branch_taken=1, target=8'h40 in the immediate cycle -> PC=8'h40, if_id_instr=00, imm_valid=0; ret_taken with ret_pc=8'h10 in the same cycle -> PC=8'h10 wins.
- Interrupt: M[1]=8'h80, intr pulse while PC=8'h25 -> intr_ret_pc=8'h25, intr_ack pulse, PC=8'h80, two NOP cycles in IF/ID.
- Wrap: PC=8'hFF, plain instruction fetched -> if_id_pc_plus1=8'h00, PC=8'h00.
